// File: rtl/operand_stage.sv
// Operand stage between decode and execute.
// Picks each source operand from register zero, the EX/MEM result, the
// write-back data or the register file, in that priority order. It detects
// load-use hazards, inserts a bubble on a stall or a flush, and registers
// the EX payload. It also keeps a saturating count of load-use stall cycles.
module operand_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [4:0]        id_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] rd_data1,
  input  logic [DATA_W-1:0] rd_data2,
  input  logic              exm_reg_write,
  input  logic [4:0]        exm_dst,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [4:0]        ex_dst,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              stall,
  output logic [15:0]       stall_count
);

  logic              ex_valid_reg;
  logic [DATA_W-1:0] ex_op_a_reg;
  logic [DATA_W-1:0] ex_op_b_reg;
  logic [DATA_W-1:0] ex_imm_reg;
  logic [CTRL_W-1:0] ex_ctrl_reg;
  logic [4:0]        ex_dst_reg;
  logic              ex_reg_write_reg;
  logic              ex_mem_read_reg;
  logic [15:0]       stall_count_reg;

  logic [4:0]        src_idx [2];
  logic [DATA_W-1:0] src_rd  [2];
  logic [DATA_W-1:0] op_a_next;
  logic [DATA_W-1:0] op_b_next;
  logic              kill;

  assign src_idx[0] = id_rs;
  assign src_idx[1] = id_rt;
  assign src_rd[0]  = rd_data1;
  assign src_rd[1]  = rd_data2;

  // Each operand is selected by the same priority chain. EX/MEM is newer
  // than write-back, so it wins when both match. The write-back bypass
  // covers a register file that is written and read on the same edge.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic [DATA_W-1:0] sel;
    assign sel = (src_idx[gi] == 5'd0)                          ? '0 :
                 (exm_reg_write && (exm_dst == src_idx[gi]))    ? exm_result :
                 (wb_reg_write  && (wb_dst  == src_idx[gi]))    ? wb_data :
                                                                  src_rd[gi];
  end

  assign op_a_next = g_fwd[0].sel;
  assign op_b_next = g_fwd[1].sel;

  // A load in EX cannot forward in time, so a consumer in ID waits one cycle.
  assign stall = id_valid && ex_valid_reg && ex_mem_read_reg && (ex_dst_reg != 5'd0) &&
                 ((id_uses_rs && (id_rs == ex_dst_reg)) ||
                  (id_uses_rt && (id_rt == ex_dst_reg)));

  assign kill = flush || stall;

  // EX payload register; a stall or a flush turns the slot into a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_reg     <= 1'b0;
      ex_reg_write_reg <= 1'b0;
      ex_mem_read_reg  <= 1'b0;
      ex_op_a_reg      <= '0;
      ex_op_b_reg      <= '0;
      ex_imm_reg       <= '0;
      ex_ctrl_reg      <= '0;
      ex_dst_reg       <= '0;
    end else begin
      ex_valid_reg     <= id_valid && !kill;
      ex_reg_write_reg <= id_valid && id_reg_write && !kill;
      ex_mem_read_reg  <= id_valid && id_mem_read && !kill;
      ex_op_a_reg      <= op_a_next;
      ex_op_b_reg      <= op_b_next;
      ex_imm_reg       <= id_imm;
      ex_ctrl_reg      <= id_ctrl;
      ex_dst_reg       <= id_dst;
    end
  end

  // Count the load-use stall cycles that really take effect (no flush),
  // and saturate at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_reg <= '0;
    end else if (stall && !flush && (stall_count_reg != 16'hFFFF)) begin
      stall_count_reg <= stall_count_reg + 16'd1;
    end
  end

  assign ex_valid     = ex_valid_reg;
  assign ex_op_a      = ex_op_a_reg;
  assign ex_op_b      = ex_op_b_reg;
  assign ex_imm       = ex_imm_reg;
  assign ex_ctrl      = ex_ctrl_reg;
  assign ex_dst       = ex_dst_reg;
  assign ex_reg_write = ex_reg_write_reg;
  assign ex_mem_read  = ex_mem_read_reg;
  assign stall_count  = stall_count_reg;

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage. In each cycle the driver applies one
// vector. It queues the stall value expected in that cycle, and it queues
// the EX state expected after the next edge. A monitor on the falling edge
// pops both queues and compares them with the outputs.
module tb_operand_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 0, id_uses_rs = 0, id_uses_rt = 0, id_reg_write = 0, id_mem_read = 0;
  logic [4:0]  id_rs = 0, id_rt = 0, id_dst = 0, exm_dst = 0, wb_dst = 0;
  logic [31:0] id_imm = 0, rd_data1 = 0, rd_data2 = 0, exm_result = 0, wb_data = 0;
  logic [7:0]  id_ctrl = 0;
  logic        exm_reg_write = 0, wb_reg_write = 0, flush = 0;

  logic        ex_valid, ex_reg_write, ex_mem_read, stall;
  logic [31:0] ex_op_a, ex_op_b, ex_imm;
  logic [7:0]  ex_ctrl;
  logic [4:0]  ex_dst;
  logic [15:0] stall_count;

  operand_stage #(.DATA_W(32), .CTRL_W(8)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_dst(id_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_imm(id_imm), .id_ctrl(id_ctrl),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .exm_reg_write(exm_reg_write), .exm_dst(exm_dst), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_dst(wb_dst), .wb_data(wb_data),
    .flush(flush),
    .ex_valid(ex_valid), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
    .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .ex_dst(ex_dst),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .stall(stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          pay;   // payload fields are meaningful (not a bubble)
    bit          v;
    logic [31:0] a, b, imm;
    logic [7:0]  ctrl;
    logic [4:0]  dst;
    bit          rw, mr;
    logic [15:0] cnt;
    string       tag;
  } exp_t;

  exp_t ex_q[$];
  bit   stall_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(string tag, bit v, logic [31:0] a, logic [31:0] b,
                              logic [31:0] imm, logic [7:0] ctrl, logic [4:0] dst,
                              bit rw, bit mr, logic [15:0] cnt);
    exp_t e;
    e.pay = 1'b1; e.v = v; e.a = a; e.b = b; e.imm = imm; e.ctrl = ctrl;
    e.dst = dst; e.rw = rw; e.mr = mr; e.cnt = cnt; e.tag = tag;
    return e;
  endfunction

  function automatic exp_t bub(string tag, logic [15:0] cnt);
    exp_t e;
    e = mk(tag, 1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, cnt);
    e.pay = 1'b0;
    return e;
  endfunction

  // Monitor: compare this cycle's stall, and the EX state queued one cycle earlier.
  always @(negedge clk) begin
    bit   s;
    exp_t e;
    cyc++;
    if (stall_q.size() > 0) begin
      s = stall_q.pop_front();
      chk("stall", {31'd0, stall}, {31'd0, s});
      if (ex_q.size() > 1) begin
        e = ex_q.pop_front();
        $display("txn %-10s ex_valid=%0d a=%h b=%h dst=%0d rw=%0d mr=%0d cnt=%0d",
                 e.tag, ex_valid, ex_op_a, ex_op_b, ex_dst, ex_reg_write, ex_mem_read, stall_count);
        chk({e.tag, ".ex_valid"},     {31'd0, ex_valid},     {31'd0, e.v});
        chk({e.tag, ".ex_reg_write"}, {31'd0, ex_reg_write}, {31'd0, e.rw});
        chk({e.tag, ".ex_mem_read"},  {31'd0, ex_mem_read},  {31'd0, e.mr});
        chk({e.tag, ".stall_count"},  {16'd0, stall_count},  {16'd0, e.cnt});
        if (e.pay) begin
          chk({e.tag, ".ex_op_a"}, ex_op_a, e.a);
          chk({e.tag, ".ex_op_b"}, ex_op_b, e.b);
          chk({e.tag, ".ex_imm"},  ex_imm,  e.imm);
          chk({e.tag, ".ex_ctrl"}, {24'd0, ex_ctrl}, {24'd0, e.ctrl});
          chk({e.tag, ".ex_dst"},  {27'd0, ex_dst},  {27'd0, e.dst});
        end
      end
    end
  end

  // Start a new cycle: wait for the edge, then return the inputs to idle.
  task automatic next();
    @(posedge clk);
    #1;
    rst = 1'b0; id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_dst = 0; id_reg_write = 0; id_mem_read = 0; id_imm = 0; id_ctrl = 0;
    rd_data1 = 0; rd_data2 = 0; exm_reg_write = 0; exm_dst = 0; exm_result = 0;
    wb_reg_write = 0; wb_dst = 0; wb_data = 0; flush = 0;
  endtask

  task automatic expect_cycle(bit s, exp_t e);
    stall_q.push_back(s);
    ex_q.push_back(e);
  endtask

  initial begin
    // c0: reset
    next(); rst = 1;
    expect_cycle(0, mk("reset0", 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // c1: reset with active inputs still clears everything
    next(); rst = 1; id_valid = 1; id_rs = 3; rd_data1 = 32'h55; id_dst = 4;
    id_reg_write = 1; id_mem_read = 1; id_imm = 32'h77; id_ctrl = 8'hAB; flush = 1;
    expect_cycle(0, mk("reset1", 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // c2: no hazard
    next(); id_valid = 1; id_rs = 3; rd_data1 = 32'h11; id_rt = 4; rd_data2 = 32'h22;
    id_uses_rs = 1; id_uses_rt = 1; id_dst = 9; id_reg_write = 1; id_imm = 32'h5; id_ctrl = 8'h3C;
    expect_cycle(0, mk("nohaz", 1, 32'h11, 32'h22, 32'h5, 8'h3C, 9, 1, 0, 0));
    // c3: EX/MEM and WB both match rs; EX/MEM wins
    next(); id_valid = 1; id_rs = 5; id_rt = 6; rd_data1 = 32'h1; rd_data2 = 32'h2;
    exm_reg_write = 1; exm_dst = 5; exm_result = 32'hAAAA;
    wb_reg_write = 1; wb_dst = 5; wb_data = 32'hBBBB; id_ctrl = 8'h01;
    expect_cycle(0, mk("dualfwd", 1, 32'hAAAA, 32'h2, 0, 8'h01, 0, 0, 0, 0));
    // c4: same, EX/MEM not writing -> WB value
    next(); id_valid = 1; id_rs = 5; id_rt = 6; rd_data1 = 32'h1; rd_data2 = 32'h2;
    exm_reg_write = 0; exm_dst = 5; exm_result = 32'hAAAA;
    wb_reg_write = 1; wb_dst = 5; wb_data = 32'hBBBB; id_ctrl = 8'h02;
    expect_cycle(0, mk("wbfwd", 1, 32'hBBBB, 32'h2, 0, 8'h02, 0, 0, 0, 0));
    // c5: WB bypass on rt, non-matching EX/MEM
    next(); id_valid = 1; id_rs = 8; rd_data1 = 32'h88; id_rt = 6; rd_data2 = 32'h66;
    wb_reg_write = 1; wb_dst = 6; wb_data = 32'hCCCC;
    exm_reg_write = 1; exm_dst = 7; exm_result = 32'h7777; id_dst = 2; id_reg_write = 1;
    expect_cycle(0, mk("wbrt", 1, 32'h88, 32'hCCCC, 0, 0, 2, 1, 0, 0));
    // c6: register zero never forwards; the instruction is a load to r7
    next(); id_valid = 1; id_rs = 0; id_rt = 0; rd_data1 = 32'h99; rd_data2 = 32'h98;
    exm_reg_write = 1; exm_dst = 0; exm_result = 32'hFFFF;
    wb_reg_write = 1; wb_dst = 0; wb_data = 32'h1234;
    id_dst = 7; id_reg_write = 1; id_mem_read = 1; id_imm = 32'h10;
    expect_cycle(0, mk("regzero", 1, 0, 0, 32'h10, 0, 7, 1, 1, 0));
    // c7: load-use on rt=7 -> stall, bubble, count 1
    next(); id_valid = 1; id_rs = 2; rd_data1 = 32'h20; id_rt = 7; rd_data2 = 32'h70;
    id_uses_rs = 1; id_uses_rt = 1; id_dst = 3; id_reg_write = 1;
    expect_cycle(1, bub("lu_bubble", 1));
    // c8: re-presented; load result now arrives on EX/MEM
    next(); id_valid = 1; id_rs = 2; rd_data1 = 32'h20; id_rt = 7; rd_data2 = 32'h70;
    id_uses_rs = 1; id_uses_rt = 1; id_dst = 3; id_reg_write = 1;
    exm_reg_write = 1; exm_dst = 7; exm_result = 32'h5A5A;
    expect_cycle(0, mk("lu_fwd", 1, 32'h20, 32'h5A5A, 0, 0, 3, 1, 0, 1));
    // c9: another load, to r10
    next(); id_valid = 1; id_rs = 1; rd_data1 = 32'h1; id_rt = 2; rd_data2 = 32'h2;
    id_dst = 10; id_reg_write = 1; id_mem_read = 1;
    expect_cycle(0, mk("load10", 1, 32'h1, 32'h2, 0, 0, 10, 1, 1, 1));
    // c10: stall and flush together -> bubble, count unchanged
    next(); id_valid = 1; id_rs = 10; id_uses_rs = 1; rd_data1 = 32'hA0; id_dst = 4; id_reg_write = 1;
    flush = 1;
    expect_cycle(1, bub("flushstall", 1));
    // c11: id_valid=0 forces the flags low, even though the id_* flags are set
    next(); id_valid = 0; id_rs = 4; rd_data1 = 32'h44; id_rt = 5; rd_data2 = 32'h55;
    id_reg_write = 1; id_mem_read = 1; id_dst = 6; id_imm = 32'h9; id_ctrl = 8'h5F;
    expect_cycle(0, mk("invalid", 0, 32'h44, 32'h55, 32'h9, 8'h5F, 6, 0, 0, 1));
    // c12: load to r12
    next(); id_valid = 1; id_dst = 12; id_reg_write = 1; id_mem_read = 1; id_rs = 1; rd_data1 = 32'h3;
    expect_cycle(0, mk("load12", 1, 32'h3, 0, 0, 0, 12, 1, 1, 1));
    // c13: load-use stall, but reset arrives at the same edge
    next(); rst = 1; id_valid = 1; id_rs = 12; id_uses_rs = 1; rd_data1 = 32'h66; id_dst = 8; id_reg_write = 1;
    expect_cycle(1, mk("rststall", 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // c14: the re-presented instruction passes with no extra stall
    next(); id_valid = 1; id_rs = 12; id_uses_rs = 1; rd_data1 = 32'h66; id_dst = 8; id_reg_write = 1;
    expect_cycle(0, mk("postrst", 1, 32'h66, 0, 0, 0, 8, 1, 0, 0));
    // c15: load to r13
    next(); id_valid = 1; id_dst = 13; id_reg_write = 1; id_mem_read = 1;
    expect_cycle(0, mk("load13", 1, 0, 0, 0, 0, 13, 1, 1, 0));
    // c16: load-use on rt=13 -> count 1 again
    next(); id_valid = 1; id_rt = 13; id_uses_rt = 1; id_dst = 14; id_reg_write = 1;
    expect_cycle(1, bub("lu2", 1));
    // c17: flush alone kills the re-presented instruction
    next(); id_valid = 1; id_rt = 13; id_uses_rt = 1; id_dst = 14; id_reg_write = 1; flush = 1;
    expect_cycle(0, bub("flush", 1));
    // c18: drain cycle; its EX expectation is never popped
    next();
    expect_cycle(0, bub("drain", 1));
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of operands, immediates and forwarded results.
REQ-002 Parameter CTRL_W, default 8, width of the opaque EX control bundle carried through unchanged.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 id_valid  input  1  decode stage presents a valid instruction.
REQ-006 id_rs, id_rt  input  5 each  source register indices, as sent to the register file read ports.
REQ-007 id_uses_rs, id_uses_rt  input  1 each  instruction actually reads rs / rt.
REQ-008 id_dst, id_reg_write, id_mem_read  input  5/1/1  destination index, writes-register flag, is-load flag.
REQ-009 id_imm  input  DATA_W  sign-extended immediate; id_ctrl  input  CTRL_W  EX control bundle.
REQ-010 rd_data1, rd_data2  input  DATA_W  register-file read data for id_rs / id_rt.
REQ-011 exm_reg_write, exm_dst, exm_result  input  1/5/DATA_W  EX/MEM forwarding source.
REQ-012 wb_reg_write, wb_dst, wb_data  input  1/5/DATA_W  write-back source; same signals drive the register-file write port.
REQ-013 flush  input  1  taken branch/jump; kill the instruction entering EX.
REQ-014 ex_valid, ex_op_a, ex_op_b, ex_imm, ex_ctrl  output  1/DATA_W/DATA_W/DATA_W/CTRL_W  registered EX-stage payload.
REQ-015 ex_dst, ex_reg_write, ex_mem_read  output  5/1/1  registered destination info.
REQ-016 stall  output  1  combinational; hold PC and IF/ID this cycle.
REQ-017 stall_count  output  16  saturating count of load-use stall cycles.

Function
REQ-018 Operand A select, priority order: id_rs==0 -> 0; exm_reg_write && exm_dst==id_rs -> exm_result; wb_reg_write && wb_dst==id_rs -> wb_data; else rd_data1.
REQ-019 Operand B select identical to REQ-018 using id_rt and rd_data2.
REQ-020 WB bypass covers the same-edge write/read case of the register file; EX/MEM wins when both match.
REQ-021 stall = id_valid && ex_valid && ex_mem_read && ex_dst!=0 && ((id_uses_rs && id_rs==ex_dst) || (id_uses_rt && id_rt==ex_dst)).
REQ-022 Normal cycle (no stall, no flush): all ex_* outputs load selected operands and id_* fields one clock after presentation; ex_valid <= id_valid.
REQ-023 Stall cycle: ex_valid <= 0, ex_reg_write <= 0, ex_mem_read <= 0 (bubble); other ex_* fields don't-care; upstream holds, so the instruction is re-presented next cycle.
REQ-024 Load-use stall lasts exactly one cycle: the bubble clears ex_mem_read, so REQ-021 deasserts next cycle and the load result arrives via exm_result.
REQ-025 Flush: next edge loads a bubble as in REQ-023; flush overrides stall when both are asserted.
REQ-026 Bubble or id_valid=0: ex_reg_write and ex_mem_read forced 0 regardless of id_* inputs.
REQ-027 stall_count increments by 1 on each edge where stall=1 and flush=0; holds at 16'hFFFF.
REQ-028 No state beyond the ex_* register and stall_count; no combinational path from ex_* outputs back to id_* inputs.

Reset
REQ-029 rst=1 at an edge: ex_valid, ex_reg_write, ex_mem_read, ex_op_a, ex_op_b, ex_imm, ex_ctrl, ex_dst, stall_count all 0; overrides stall and flush.
REQ-030 stall is 0 in the first cycle after reset, since ex_valid=0.
REQ-031 Reset asserted mid-stall discards the pending bubble; the first post-reset instruction passes with no extra stall.

Verification
REQ-032 No hazard: rs=3, rd_data1=0x11, rt=4, rd_data2=0x22 -> next cycle ex_op_a=0x11, ex_op_b=0x22, ex_valid=1, stall=0.
REQ-033 Dual forward: exm_dst=5 with exm_result=0xAAAA, wb_dst=5 with wb_data=0xBBBB, rs=5 -> ex_op_a=0xAAAA; exm_reg_write=0 -> 0xBBBB.
REQ-034 Register zero: rs=0, exm_dst=0, exm_reg_write=1, exm_result=0xFFFF -> ex_op_a=0.
REQ-035 Load-use: load with dst=7 in EX, ID uses rt=7 -> stall=1 for exactly 1 cycle, one bubble (ex_valid=0), stall_count=1, then ex_op_b=exm_result.
REQ-036 Flush+stall in the same cycle -> bubble, stall_count unchanged; rst mid-stream -> all outputs 0 next edge.
